// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fsm_pkg
// Purpose  : Shared types and helper functions for the step/ring FSM.
//            - dir_t    : step direction (backward / forward)
//            - step_t   : result of one ring step (next index + wrap flag)
//            - next_idx : modulo step with explicit wrap detection
//            - encode_y : binary or one-hot encoding of a state index
// Revision : 1.0 - initial release
// ============================================================================
package fsm_pkg;

  // Ring indices never exceed 16 states, so 4 bits always hold an index.
  localparam int c_IDX_W = 4;
  localparam int c_Y_W   = 16;

  typedef enum logic {
    DIR_BWD = 1'b0,
    DIR_FWD = 1'b1
  } dir_t;

  typedef struct packed {
    logic [c_IDX_W-1:0] idx;
    logic               wrap;
  } step_t;

  // Step one position around a ring of n states. The wrap is found by
  // comparison rather than by overflow so non-power-of-2 rings never
  // produce an index equal to n.
  function automatic step_t next_idx(input logic [c_IDX_W-1:0] idx,
                                     input dir_t               dir,
                                     input logic [c_IDX_W:0]   n);
    step_t              r;
    logic [c_IDX_W:0]   last;
    last   = n - (c_IDX_W+1)'(1);
    r.wrap = 1'b0;
    if (dir == DIR_FWD) begin
      if ({1'b0, idx} == last) begin
        r.idx  = '0;
        r.wrap = 1'b1;
      end else begin
        r.idx = idx + c_IDX_W'(1);
      end
    end else begin
      if (idx == '0) begin
        r.idx  = last[c_IDX_W-1:0];
        r.wrap = 1'b1;
      end else begin
        r.idx = idx - c_IDX_W'(1);
      end
    end
    return r;
  endfunction

  // Binary index (zero-extended) or one-hot vector of the index.
  function automatic logic [c_Y_W-1:0] encode_y(input logic [c_IDX_W-1:0] idx,
                                                input logic               onehot);
    if (onehot) begin
      return c_Y_W'(1) << idx;
    end else begin
      return c_Y_W'(idx);
    end
  endfunction

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/fsm_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : fsm_idle_timer
// Purpose  : Saturating idle counter with synchronous clear and an expire
//            pulse. expire_o is asserted combinationally on the stalled cycle
//            in which the count already stands at TIMEOUT-1; the counter then
//            clears itself.
// Ports    : clk_i    - rising-edge clock
//            rst_ni   - asynchronous active-low reset
//            clr_i    - clear the count
//            inc_i    - count one idle cycle
//            expire_o - idle limit reached on this cycle
// Revision : 1.0 - initial release
// ============================================================================
module fsm_idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

  logic [c_CW-1:0] cnt_q;

  assign expire_o = inc_i && (cnt_q == c_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i || expire_o) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != c_LAST)) begin
      cnt_q <= cnt_q + c_CW'(1);
    end
  end

endmodule : fsm_idle_timer
`default_nettype wire

// File: rtl/fsm_step_ring.sv
`default_nettype none
// ============================================================================
// Module   : fsm_step_ring
// Purpose  : Parametrised step/ring state machine. Walks NUM_STATES states in
//            a ring; state k advances when i_i[k] is high, in the direction
//            given by dir_i, unless hold_i freezes it. y_o shows the state as
//            a binary index or one-hot vector; wrap_o pulses on a ring wrap.
//            Optional feature macro: FSM_TIMEOUT_EN - forces a return to
//            state 0 after TIMEOUT consecutive stalled cycles and pulses
//            timeout_o. Without it, timeout_o is tied low.
// Ports    : clk_i     - rising-edge clock
//            rst_ni    - asynchronous active-low reset
//            i_i       - per-state advance conditions
//            dir_i     - 1: forward, 0: backward
//            hold_i    - freeze state (overrides i_i)
//            y_o       - registered state encoding
//            wrap_o    - registered one-cycle wrap pulse
//            timeout_o - registered one-cycle forced-return pulse
// Revision : 1.0 - initial release
// ============================================================================
module fsm_step_ring
  import fsm_pkg::*;
#(
  parameter int NUM_STATES = 4,
  parameter int YW         = 4,
  parameter int ONEHOT     = 0,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_STATES-1:0] i_i,
  input  logic                  dir_i,
  input  logic                  hold_i,
  output logic [YW-1:0]         y_o,
  output logic                  wrap_o,
  output logic                  timeout_o
);

  localparam int                 c_SW    = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam logic [YW-1:0]      c_Y_RST = (ONEHOT != 0) ? YW'(1) : '0;
  localparam logic [c_IDX_W:0]   c_N     = (c_IDX_W+1)'(NUM_STATES);

  logic [c_SW-1:0] s_q, s_d;
  logic [YW-1:0]   y_q, y_d;
  logic            wrap_q, wrap_d;
  logic            timeout_q;

  logic            w_cond;
  logic            w_adv;
  logic            w_expire;
  step_t           w_step;

  // Only the condition bit of the current state matters.
  assign w_cond = i_i[s_q];
  assign w_adv  = !hold_i && w_cond;
  assign w_step = next_idx(c_IDX_W'(s_q), dir_t'(dir_i), c_N);

`ifdef FSM_TIMEOUT_EN
  logic w_stall;

  // A stall is a non-held, non-advancing cycle away from state 0; anything
  // else restarts the idle count.
  assign w_stall = !hold_i && !w_cond && (s_q != '0);

  fsm_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (!w_stall),
    .inc_i    (w_stall),
    .expire_o (w_expire)
  );
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = (TIMEOUT > 0);
  assign w_expire             = 1'b0;
`endif

  always_comb begin
    s_d    = s_q;
    wrap_d = 1'b0;
    if (w_expire) begin
      s_d = '0;
    end else if (w_adv) begin
      s_d    = c_SW'(w_step.idx);
      wrap_d = w_step.wrap;
    end
    // y is encoded from the next state so it lines up with s after the edge.
    y_d = YW'(encode_y(c_IDX_W'(s_d), ONEHOT != 0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q       <= '0;
      y_q       <= c_Y_RST;
      wrap_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      y_q       <= y_d;
      wrap_q    <= wrap_d;
      timeout_q <= w_expire;
    end
  end

  assign y_o       = y_q;
  assign wrap_o    = wrap_q;
  assign timeout_o = timeout_q;

endmodule : fsm_step_ring
`default_nettype wire

// File: tb/tb_fsm_step_ring.sv
`default_nettype none
// ============================================================================
// Module   : tb_fsm_step_ring
// Purpose  : Self-checking bench for fsm_step_ring. Drives a 4-state binary
//            instance and a 5-state one-hot instance side by side and compares
//            both against a ring model built from modulo arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fsm_step_ring;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i4;
  logic [4:0] i5;
  logic       dir;
  logic       hold;
  logic [3:0] y4;
  logic [4:0] y5;
  logic       wrap4, wrap5, to4, to5;

  always #5 clk = ~clk;

  fsm_step_ring #(.NUM_STATES(4), .YW(4), .ONEHOT(0), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .i_i(i4), .dir_i(dir), .hold_i(hold),
    .y_o(y4), .wrap_o(wrap4), .timeout_o(to4)
  );

  fsm_step_ring #(.NUM_STATES(5), .YW(5), .ONEHOT(1), .TIMEOUT(TO)) dut_oh (
    .clk_i(clk), .rst_ni(rst_n), .i_i(i5), .dir_i(dir), .hold_i(hold),
    .y_o(y5), .wrap_o(wrap5), .timeout_o(to5)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: current ring position and consecutive stalled cycles.
  int ms[2];
  int stalls[2];
  int nst[2] = '{4, 5};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_edge(input int k, input int iv, output int e_wrap, output int e_to);
    int cur, nxt;
    cur    = ms[k];
    nxt    = cur;
    e_wrap = 0;
    e_to   = 0;
    if (!hold && (((iv >> cur) & 1) == 1)) begin
      nxt       = (cur + (dir ? 1 : nst[k] - 1)) % nst[k];
      e_wrap    = dir ? int'(nxt < cur) : int'(nxt > cur);
      stalls[k] = 0;
    end else if (!hold && cur != 0) begin
`ifdef FSM_TIMEOUT_EN
      stalls[k]++;
      if (stalls[k] == TO) begin
        nxt       = 0;
        e_to      = 1;
        stalls[k] = 0;
      end
`endif
    end else begin
      stalls[k] = 0;
    end
    ms[k] = nxt;
  endtask

  task automatic step(input string tag);
    int ew0, et0, ew1, et1;
    model_edge(0, int'(i4), ew0, et0);
    model_edge(1, int'(i5), ew1, et1);
    @(posedge clk);
    #1;
    check({tag, ".y"},     int'(y4),    ms[0]);
    check({tag, ".wrap"},  int'(wrap4), ew0);
    check({tag, ".to"},    int'(to4),   et0);
    check({tag, ".ohy"},   int'(y5),    1 << ms[1]);
    check({tag, ".ohwrap"}, int'(wrap5), ew1);
    check({tag, ".ohto"},  int'(to5),   et1);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k]     = 0;
      stalls[k] = 0;
    end
  endtask

  // Drop reset between edges and expect outputs to clear without a clock.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".y"},    int'(y4),    0);
    check({tag, ".wrap"}, int'(wrap4), 0);
    check({tag, ".to"},   int'(to4),   0);
    check({tag, ".ohy"},  int'(y5),    1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    i4    = '0;
    i5    = '0;
    dir   = 1'b1;
    hold  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst.y",    int'(y4),    0);
    check("rst.wrap", int'(wrap4), 0);
    check("rst.to",   int'(to4),   0);
    check("rst.ohy",  int'(y5),    1);
    @(negedge clk);
    rst_n = 1'b1;

    // Free run forward through several wraps.
    i4 = 4'hF; i5 = 5'h1F; dir = 1'b1; hold = 1'b0;
    repeat (10) step("run");        // 4-state ring ends at index 2

    // Reverse from index 2, wrapping backward.
    dir = 1'b0;
    repeat (4) step("rev");         // 1,0,3,2

    // Gated: bit 2 low keeps the ring at index 2.
    i4 = 4'b1011; i5 = 5'b11011;
    repeat (3) step("gate");
    i4 = 4'hF; i5 = 5'h1F; hold = 1'b1;
    repeat (3) step("hold");
    hold = 1'b0; dir = 1'b1;
    step("release");                // index 3

    async_reset("arst");

    // Stall away from state 0, then the same with hold.
    i4 = 4'b0001; i5 = 5'b00001; dir = 1'b1; hold = 1'b0;
    step("to1");
    i4 = '0; i5 = '0;
    repeat (12) step("stall");
    i4 = 4'b0001; i5 = 5'b00001;
    step("to1b");
    i4 = '0; i5 = '0; hold = 1'b1;
    repeat (12) step("holdstall");
    hold = 1'b0;
    repeat (10) step("stall2");

    // Randomised blocks: free random cycles mixed with long stall runs.
    for (int b = 0; b < 40; b++) begin
      if ($urandom_range(0, 2) == 0) begin
        i4 = '0; i5 = '0; hold = 1'b0; dir = 1'($urandom);
        repeat (10) step("rstall");
      end else begin
        for (int c = 0; c < 8; c++) begin
          i4   = 4'($urandom);
          i5   = 5'($urandom);
          dir  = 1'($urandom);
          hold = ($urandom_range(0, 3) == 0);
          step("rand");
        end
      end
      if (b == 20) async_reset("arst2");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fsm_step_ring
`default_nettype wire
